vit_conv_dma_dat_gen: RTL and testbench
=======================================

Name: vit_conv_dma_dat_gen

Overview:
Parametrised read-command generator for the ViT convolution input-feature DMA. It walks a 3-level loop: bursts within a line (innermost), then lines, then input-channel groups (outermost, stepped by surface stride). For each burst it issues one MCIF read request over a valid/ready handshake. It sits between the CSR block and MCIF and replaces the fixed single-group conv0 data fetcher.

Parameters:
LOG2_BURST, 4, log2 of the maximum AXI burst length in beats (BL = 2^LOG2_BURST)
ADDR_W, 32, address and stride width
BEAT_BYTES, 32, bytes per AXI beat; the address step between consecutive bursts is BL*BEAT_BYTES
LINE_W, 12, width of the beats-per-line field
H_W, 11, width of the line-count field
CH_W, 8, width of the channel-group-count field

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle start pulse from CSR
line_beats_minus1  in  LINE_W  beats per line minus 1
hin_minus1  in  H_W  lines per surface minus 1
ch_grp_minus1  in  CH_W  channel groups minus 1
dat_base_addr  in  ADDR_W  base address, passed through in pd
line_stride  in  ADDR_W  byte offset between lines
surface_stride  in  ADDR_W  byte offset between channel groups
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
rd_req_vld  out  1  request valid
rd_req_rdy  in  1  MCIF ready
rd_req_pd  out  LOG2_BURST+2*ADDR_W  {len, dat_base_addr, offset}

Behaviour:
- Reset values: busy=0, done=0, rd_req_vld=0, all counters and offset accumulators=0.
- start is accepted only when busy=0. Acceptance latches all configuration inputs and zeroes the counters. busy=1 from the next cycle. start while busy=1 is ignored.
- rd_req_vld = busy, driven directly from a register.
- A request is accepted on rd_req_vld&rd_req_rdy. pd must stay stable while vld=1 and rdy=0.
- Bursts per line: NB = (line_beats_minus1>>LOG2_BURST)+1.
- k counts 0..NB-1; it advances on each accepted request and wraps to 0 on the last burst.
- h advances when k wraps; it wraps after hin_minus1.
- c advances when h wraps; it ends the job after ch_grp_minus1.
- len field:
  - k<NB-1: BL-1
  - k==NB-1: line_beats_minus1[LOG2_BURST-1:0]
  - an exact multiple of BL therefore gives a final len of BL-1.
- offset = c*surface_stride + h*line_stride + k*BL*BEAT_BYTES, modulo 2^ADDR_W.
  - Built with three incremental accumulators; no multipliers.
  - An inner accumulator is cleared when its loop wraps.
- Final accept (k, h, c all at max): busy and vld drop on the next edge, done=1 for exactly that next cycle.
- A start arriving in the done cycle is accepted, so back-to-back jobs are possible.
- Total requests per job = NB*(hin_minus1+1)*(ch_grp_minus1+1).
- rst_n low mid-job aborts immediately: all outputs return to reset values and no done is issued.
- Configuration inputs may change while busy without effect.

Optional Feature:
VIT_DMA_DAT_STALL_CNT_EN
- Defined: adds output stall_cnt [31:0].
  - Counts cycles with rd_req_vld&~rd_req_rdy.
  - Cleared on accepted start.
  - Saturates at 0xFFFFFFFF.
  - Holds its value after done.
  - Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Defaults, line_beats_minus1=39, hin_minus1=0, ch_grp_minus1=0, rdy=1 -> 3 requests: len 15,15,7 at offsets 0x0, 0x200, 0x400; done 1 cycle after the 3rd accept.
- line_beats_minus1=31, hin_minus1=1, line_stride=0x1000, ch_grp_minus1=1, surface_stride=0x10000 -> 8 requests, all len 15, offsets 0x0, 0x200, 0x1000, 0x1200, 0x10000, 0x10200, 0x11000, 0x11200.
- line_beats_minus1=0, hin_minus1=2, line_stride=0x40 -> 3 requests, len 0, offsets 0x0, 0x40, 0x80.
- Random rdy backpressure (50%) on the first case -> pd stable while vld&~rdy, the same 3 requests, no drops or duplicates; with the macro defined, stall_cnt equals the number of stalled cycles.
- start pulsed while busy, and again in the done cycle -> the first is ignored, the second launches a new job with vld=1 on the next cycle.
- rst_n asserted after the 2nd accept -> busy=vld=done=0 immediately; the next start restarts at offset 0x0.

Source files
------------

// File: rtl/vit_conv_dma_dat_gen.sv
// ViT conv input-feature DMA read-command generator: bursts -> lines -> channel groups, one MCIF request per burst.
// Latency: vld one cycle after start; backpressure holds pd stable. Optional stall counter: VIT_DMA_DAT_STALL_CNT_EN.
module vit_conv_dma_dat_gen #(
    parameter int LOG2_BURST = 4,
    parameter int ADDR_W     = 32,
    parameter int BEAT_BYTES = 32,
    parameter int LINE_W     = 12,
    parameter int H_W        = 11,
    parameter int CH_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [LINE_W-1:0]              line_beats_minus1,
    input  logic [H_W-1:0]                 hin_minus1,
    input  logic [CH_W-1:0]                ch_grp_minus1,
    input  logic [ADDR_W-1:0]              dat_base_addr,
    input  logic [ADDR_W-1:0]              line_stride,
    input  logic [ADDR_W-1:0]              surface_stride,
    output logic                           busy,
    output logic                           done,
    output logic                           rd_req_vld,
    input  logic                           rd_req_rdy,
    output logic [LOG2_BURST+2*ADDR_W-1:0] rd_req_pd
`ifdef VIT_DMA_DAT_STALL_CNT_EN
    ,
    output logic [31:0]                    stall_cnt
`endif
);

    localparam int KW = LINE_W - LOG2_BURST;
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'((1 << LOG2_BURST) * BEAT_BYTES);

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [LINE_W-1:0] lbm1_q;
    logic [H_W-1:0]    hm1_q;
    logic [CH_W-1:0]   cm1_q;
    logic [ADDR_W-1:0] base_q, lstride_q, sstride_q;
    logic [KW-1:0]     k_q, k_d;
    logic [H_W-1:0]    h_q, h_d;
    logic [CH_W-1:0]   c_q, c_d;
    logic [ADDR_W-1:0] k_off_q, k_off_d, h_off_q, h_off_d, c_off_q, c_off_d;
    logic              last_k, last_h, last_c, start_acc;
    logic [LOG2_BURST-1:0] len;

    assign start_acc = ~busy_q & start;
    assign last_k    = (k_q == lbm1_q[LINE_W-1:LOG2_BURST]);
    assign last_h    = (h_q == hm1_q);
    assign last_c    = (c_q == cm1_q);
    // Only the last burst of a line can be short; a multiple of BL yields all-ones here too.
    assign len       = last_k ? lbm1_q[LOG2_BURST-1:0] : '1;

    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        k_d     = k_q;
        h_d     = h_q;
        c_d     = c_q;
        k_off_d = k_off_q;
        h_off_d = h_off_q;
        c_off_d = c_off_q;
        if (start_acc) begin
            busy_d  = 1'b1;
            k_d     = '0;
            h_d     = '0;
            c_d     = '0;
            k_off_d = '0;
            h_off_d = '0;
            c_off_d = '0;
        end else if (busy_q && rd_req_rdy) begin
            if (!last_k) begin
                k_d     = k_q + 1'b1;
                k_off_d = k_off_q + BURST_STEP;
            end else begin
                k_d     = '0;
                k_off_d = '0;
                if (!last_h) begin
                    h_d     = h_q + 1'b1;
                    h_off_d = h_off_q + lstride_q;
                end else begin
                    h_d     = '0;
                    h_off_d = '0;
                    if (!last_c) begin
                        c_d     = c_q + 1'b1;
                        c_off_d = c_off_q + sstride_q;
                    end else begin
                        c_d     = '0;
                        c_off_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lbm1_q    <= '0;
            hm1_q     <= '0;
            cm1_q     <= '0;
            base_q    <= '0;
            lstride_q <= '0;
            sstride_q <= '0;
            k_q       <= '0;
            h_q       <= '0;
            c_q       <= '0;
            k_off_q   <= '0;
            h_off_q   <= '0;
            c_off_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            k_q     <= k_d;
            h_q     <= h_d;
            c_q     <= c_d;
            k_off_q <= k_off_d;
            h_off_q <= h_off_d;
            c_off_q <= c_off_d;
            if (start_acc) begin
                lbm1_q    <= line_beats_minus1;
                hm1_q     <= hin_minus1;
                cm1_q     <= ch_grp_minus1;
                base_q    <= dat_base_addr;
                lstride_q <= line_stride;
                sstride_q <= surface_stride;
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_req_vld = busy_q;
    assign rd_req_pd  = {len, base_q, c_off_q + h_off_q + k_off_q};

`ifdef VIT_DMA_DAT_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (start_acc) begin
            stall_cnt_q <= '0;
        end else if (busy_q && !rd_req_rdy && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_vit_conv_dma_dat_gen.sv
// Directed bench for vit_conv_dma_dat_gen with a queue of expected read requests.
module tb_vit_conv_dma_dat_gen;

    logic        clk = 1'b0;
    logic        rst_n, start, rd_req_rdy;
    logic [11:0] line_beats_minus1;
    logic [10:0] hin_minus1;
    logic [7:0]  ch_grp_minus1;
    logic [31:0] dat_base_addr, line_stride, surface_stride;
    logic        busy, done, rd_req_vld;
    logic [67:0] rd_req_pd;
`ifdef VIT_DMA_DAT_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [67:0] expq[$];

    always #5 clk = ~clk;

    vit_conv_dma_dat_gen dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .line_beats_minus1 (line_beats_minus1),
        .hin_minus1        (hin_minus1),
        .ch_grp_minus1     (ch_grp_minus1),
        .dat_base_addr     (dat_base_addr),
        .line_stride       (line_stride),
        .surface_stride    (surface_stride),
        .busy              (busy),
        .done              (done),
        .rd_req_vld        (rd_req_vld),
        .rd_req_rdy        (rd_req_rdy),
        .rd_req_pd         (rd_req_pd)
`ifdef VIT_DMA_DAT_STALL_CNT_EN
        ,
        .stall_cnt         (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_cfg(input logic [11:0] lb, input logic [10:0] hm, input logic [7:0] cm,
                             input logic [31:0] base, input logic [31:0] ls, input logic [31:0] ss);
        line_beats_minus1 = lb;
        hin_minus1        = hm;
        ch_grp_minus1     = cm;
        dat_base_addr     = base;
        line_stride       = ls;
        surface_stride    = ss;
    endtask

    task automatic push_job(input logic [11:0] lb, input logic [10:0] hm, input logic [7:0] cm,
                            input logic [31:0] base, input logic [31:0] ls, input logic [31:0] ss);
        int nb;
        nb = int'(lb >> 4) + 1;
        for (int c = 0; c <= int'(cm); c++)
            for (int h = 0; h <= int'(hm); h++)
                for (int k = 0; k < nb; k++) begin
                    logic [3:0]  len;
                    logic [31:0] off;
                    len = (k < nb - 1) ? 4'hF : lb[3:0];
                    off = 32'(c) * ss + 32'(h) * ls + 32'(k) * 32'h200;
                    expq.push_back({len, base, off});
                end
    endtask

    // Entered and left at a falling edge; config is scrambled after start to prove it was latched.
    task automatic launch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_cfg(12'($urandom), 11'($urandom), 8'($urandom), $urandom, $urandom, $urandom);
        chk("busy_after_start", 68'(busy), 68'(1));
    endtask

    task automatic drain(input int pct);
        int          stalls = 0;
        int          cyc = 0;
        bit          have_hold = 0;
        logic [67:0] hold;
        while (expq.size() > 0 && cyc < 500) begin
            chk("vld_while_pending", 68'(rd_req_vld), 68'(1));
            if (have_hold) chk("pd_stable", rd_req_pd, hold);
            rd_req_rdy = ($urandom_range(99) < pct);
            if (rd_req_vld && rd_req_rdy) begin
                chk("req_pd", rd_req_pd, expq.pop_front());
                have_hold = 0;
            end else if (rd_req_vld) begin
                stalls++;
                hold      = rd_req_pd;
                have_hold = 1;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 500) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", expq.size());
            expq.delete();
        end
        rd_req_rdy = 1'b0;
        chk("done_pulse", 68'(done), 68'(1));
        chk("busy_end", 68'(busy), 68'(0));
        chk("vld_end", 68'(rd_req_vld), 68'(0));
`ifdef VIT_DMA_DAT_STALL_CNT_EN
        chk("stall_cnt", 68'(stall_cnt), 68'(stalls));
`endif
        @(negedge clk);
        chk("done_one_cycle", 68'(done), 68'(0));
        chk("vld_stays_low", 68'(rd_req_vld), 68'(0));
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        rd_req_rdy = 1'b0;
        drive_cfg(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_busy", 68'(busy), 68'(0));
        chk("rst_done", 68'(done), 68'(0));
        chk("rst_vld", 68'(rd_req_vld), 68'(0));
`ifdef VIT_DMA_DAT_STALL_CNT_EN
        chk("rst_stall", 68'(stall_cnt), 68'(0));
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Short last burst: 40 beats -> 16,16,8
        drive_cfg(39, 0, 0, 32'hA000_0000, 0, 0);
        push_job(39, 0, 0, 32'hA000_0000, 0, 0);
        launch();
        drain(100);

        // Full loop nest with exact multiple of BL
        drive_cfg(31, 1, 1, 32'h1234_5678, 32'h1000, 32'h1_0000);
        push_job(31, 1, 1, 32'h1234_5678, 32'h1000, 32'h1_0000);
        launch();
        drain(100);

        // Single-beat lines
        drive_cfg(0, 2, 0, 32'h0, 32'h40, 32'h0);
        push_job(0, 2, 0, 32'h0, 32'h40, 32'h0);
        launch();
        drain(100);

        // Random backpressure
        drive_cfg(39, 0, 0, 32'hA000_0000, 0, 0);
        push_job(39, 0, 0, 32'hA000_0000, 0, 0);
        launch();
        drain(50);

        // Start while busy is ignored; start in the done cycle chains a new job
        drive_cfg(0, 2, 0, 32'h5000_0000, 32'h40, 32'h0);
        push_job(0, 2, 0, 32'h5000_0000, 32'h40, 32'h0);
        start = 1'b1;
        @(negedge clk);
        drive_cfg(39, 0, 0, 32'hB000_0000, 0, 0);
        start      = 1'b1;
        rd_req_rdy = 1'b1;
        chk("b2b_vld", 68'(rd_req_vld), 68'(1));
        chk("b2b_req0", rd_req_pd, expq.pop_front());
        @(negedge clk);
        start = 1'b0;
        chk("b2b_req1", rd_req_pd, expq.pop_front());
        @(negedge clk);
        chk("b2b_req2", rd_req_pd, expq.pop_front());
        @(negedge clk);
        rd_req_rdy = 1'b0;
        chk("b2b_done", 68'(done), 68'(1));
        start = 1'b1;
        push_job(39, 0, 0, 32'hB000_0000, 0, 0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_next", 68'(busy), 68'(1));
        drain(100);

        // Asynchronous reset mid-job, then clean restart
        drive_cfg(39, 0, 0, 32'hC000_0000, 0, 0);
        push_job(39, 0, 0, 32'hC000_0000, 0, 0);
        launch();
        rd_req_rdy = 1'b1;
        chk("pre_rst_req0", rd_req_pd, expq.pop_front());
        @(negedge clk);
        chk("pre_rst_req1", rd_req_pd, expq.pop_front());
        @(negedge clk);
        rst_n      = 1'b0;
        rd_req_rdy = 1'b0;
        #1;
        chk("abort_busy", 68'(busy), 68'(0));
        chk("abort_vld", 68'(rd_req_vld), 68'(0));
        chk("abort_done", 68'(done), 68'(0));
        expq.delete();
        @(negedge clk);
        chk("abort_no_done", 68'(done), 68'(0));
        rst_n = 1'b1;
        @(negedge clk);
        drive_cfg(39, 0, 0, 32'hC000_0000, 0, 0);
        push_job(39, 0, 0, 32'hC000_0000, 0, 0);
        launch();
        drain(100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
